rs_burst_deserializer: RTL and testbench
========================================

# rs_burst_deserializer

Upstream feeder for the RS SSC/DSD decoder. Collects one 8-beat burst of 39-bit memory beats, transposes it into the 312-bit symbol-ordered codeword (39 symbols × 8 bits, symbols 38..36 being check symbols), and presents it to the combinational decoder through a valid/ready register stage. Double-buffered: the next burst can be assembled while the current codeword waits for the consumer.

## Interface
- LANES, 39, beat width; one lane per symbol.
- BEATS, 8, beats per burst; equals symbol width. CW_W = LANES*BEATS (312) is derived, not overridable.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat present.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  LANES  beat payload.
- in_last  in  1  marks final beat of burst.
- cw_valid  out  1  codeword register holds a codeword.
- cw_ready  in  1  decoder side accepts codeword.
- codeword  out  CW_W  to decoder codeword input.
- frame_err  out  1  one-cycle pulse on framing violation.
- One clock; reset is asynchronous and active-low (clk, rst_n).

## Operation
- Transpose: beat b (0 = first), lane i → codeword[8*i + b]. Symbol i = lane i over all beats, beat 0 = LSB.
- beat_cnt 0..BEATS-1 counts accepted beats; assembly register written at that beat's bit slice.
- States: FILL (accepting beats), HOLD (full burst assembled, output register occupied and not draining).
- FILL, final beat (beat_cnt = 7, in_last = 1) accepted: if output empty or (cw_valid && cw_ready) same cycle → load output register, cw_valid = 1, stay FILL, beat_cnt = 0. Otherwise latch into assembly, go HOLD.
- HOLD: in_ready = 0. When output drains (cw_valid && cw_ready), transfer assembly → output next edge, cw_valid stays 1, return FILL.
- in_ready = 1 in FILL, 0 in HOLD.
- Framing: in_last = 1 at beat_cnt < 7, or in_last = 0 at beat_cnt = 7 → beat accepted, whole burst discarded (no codeword), beat_cnt = 0, frame_err pulses the following cycle. Output register unaffected.
- cw_valid drops after handshake when no new codeword loads that edge. codeword stable while cw_valid && !cw_ready.
- No partial codeword ever reaches the output.

## Timing
- Reset: in_ready = 1 after release, cw_valid = 0, codeword = 0, frame_err = 0, beat_cnt = 0, state FILL; assembly cleared. Reset mid-burst or mid-hold discards all content.
- Latency: final beat accepted on edge N → cw_valid = 1 and codeword valid after edge N.
- Throughput: one codeword per 8 cycles with cw_ready held high; back-to-back bursts, no bubble.
- Simultaneous drain and final-beat load: old codeword handshakes, new one appears next cycle, cw_valid never drops.
- Stall depth: one codeword in output + one in assembly; in_ready falls only after a ninth... i.e. after a second full burst completes while output is held.
- frame_err registered, exactly one cycle per violation.

## Configuration
- RS_DESER_POISON_EN defined: adds in_poison (in, 1) and cw_poison (out, 1). cw_poison = OR of in_poison over the 8 accepted beats, travels with its codeword through HOLD/output; reset 0; discarded with framing-errored bursts.
- Undefined: ports and logic absent; behaviour otherwise identical.

## Test plan
- Single burst, lane 37 = 1 on beats 0,2,3,5,7, all else 0, cw_ready = 1 → codeword[303:296] = 8'hAD, rest 0, cw_valid one cycle after final beat.
- Lane i driven with pattern giving symbol value i for all 39 lanes → codeword[8*i+7:8*i] = i for every i.
- cw_ready = 0, three bursts offered back-to-back → first in output, second in assembly, in_ready = 0 on third burst's beat 0; release cw_ready → codewords 1, 2, 3 in order, no loss.
- in_last at beat 3 → frame_err one pulse, no cw_valid; following clean burst produces correct codeword.
- Assert rst_n low at beat 5 then release → all outputs 0, next burst decoded correctly from beat 0.
- With RS_DESER_POISON_EN, in_poison on beat 6 only → cw_poison = 1 with that codeword, 0 on the next.

Source files
------------

// File: rtl/rs_burst_deserializer.sv
// ============================================================================
// Module      : rs_burst_deserializer
// Description : Collects an 8-beat burst of 39-bit beats, transposes it into a
//               symbol-ordered codeword and holds it in a valid/ready register.
//               Optional poison tracking is enabled with RS_DESER_POISON_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_burst_deserializer #(
    parameter int  LANES = 39,
    parameter int  BEATS = 8,
    localparam int CW_W  = LANES * BEATS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LANES-1:0] in_data,
    input  logic             in_last,
`ifdef RS_DESER_POISON_EN
    input  logic             in_poison,
    output logic             cw_poison,
`endif
    output logic             cw_valid,
    input  logic             cw_ready,
    output logic [CW_W-1:0]  codeword,
    output logic             frame_err
);

    localparam int CNT_W = $clog2(BEATS);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CW_W-1:0]    asm_q, asm_d;
    logic [CW_W-1:0]    cw_q, cw_d;
    logic               cw_valid_q, cw_valid_d;
    logic               frame_err_q, frame_err_d;
    logic [CW_W-1:0]    merged;
    logic               accept, drain, last_beat;
`ifdef RS_DESER_POISON_EN
    logic               poison_acc_q, poison_acc_d;
    logic               asm_poison_q, asm_poison_d;
    logic               cw_poison_q, cw_poison_d;
    logic               burst_poison;
`endif

    // Assembly contents with the current beat dropped into every symbol.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [BEATS-1:0] sym;
        always_comb begin
            sym             = asm_q[BEATS*g +: BEATS];
            sym[beat_cnt_q] = in_data[g];
        end
        assign merged[BEATS*g +: BEATS] = sym;
    end

    assign accept    = in_valid && (state_q == FILL);
    assign drain     = cw_valid_q && cw_ready;
    assign last_beat = (beat_cnt_q == CNT_W'(BEATS - 1));
`ifdef RS_DESER_POISON_EN
    assign burst_poison = poison_acc_q | in_poison;
`endif

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        asm_d       = asm_q;
        cw_d        = cw_q;
        cw_valid_d  = cw_valid_q && !drain;
        frame_err_d = 1'b0;
`ifdef RS_DESER_POISON_EN
        poison_acc_d = poison_acc_q;
        asm_poison_d = asm_poison_q;
        cw_poison_d  = cw_poison_q;
`endif
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (in_last != last_beat) begin
                        // Burst discarded; stale assembly bits are overwritten by the next burst.
                        beat_cnt_d  = '0;
                        frame_err_d = 1'b1;
`ifdef RS_DESER_POISON_EN
                        poison_acc_d = 1'b0;
`endif
                    end else if (last_beat) begin
                        beat_cnt_d = '0;
`ifdef RS_DESER_POISON_EN
                        poison_acc_d = 1'b0;
`endif
                        if (!cw_valid_q || drain) begin
                            cw_d       = merged;
                            cw_valid_d = 1'b1;
`ifdef RS_DESER_POISON_EN
                            cw_poison_d = burst_poison;
`endif
                        end else begin
                            asm_d   = merged;
                            state_d = HOLD;
`ifdef RS_DESER_POISON_EN
                            asm_poison_d = burst_poison;
`endif
                        end
                    end else begin
                        asm_d      = merged;
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
`ifdef RS_DESER_POISON_EN
                        poison_acc_d = burst_poison;
`endif
                    end
                end
            end
            HOLD: begin
                if (drain) begin
                    cw_d       = asm_q;
                    cw_valid_d = 1'b1;
                    state_d    = FILL;
`ifdef RS_DESER_POISON_EN
                    cw_poison_d = asm_poison_q;
`endif
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            beat_cnt_q  <= '0;
            asm_q       <= '0;
            cw_q        <= '0;
            cw_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef RS_DESER_POISON_EN
            poison_acc_q <= 1'b0;
            asm_poison_q <= 1'b0;
            cw_poison_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            asm_q       <= asm_d;
            cw_q        <= cw_d;
            cw_valid_q  <= cw_valid_d;
            frame_err_q <= frame_err_d;
`ifdef RS_DESER_POISON_EN
            poison_acc_q <= poison_acc_d;
            asm_poison_q <= asm_poison_d;
            cw_poison_q  <= cw_poison_d;
`endif
        end
    end

    assign in_ready  = (state_q == FILL);
    assign cw_valid  = cw_valid_q;
    assign codeword  = cw_q;
    assign frame_err = frame_err_q;
`ifdef RS_DESER_POISON_EN
    assign cw_poison = cw_poison_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rs_burst_deserializer.sv
// ============================================================================
// Module      : tb_rs_burst_deserializer
// Description : Randomised bench for rs_burst_deserializer against a
//               queue-based burst model (RS_DESER_POISON_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rs_burst_deserializer;

    localparam int LANES = 39;
    localparam int BEATS = 8;
    localparam int CW_W  = LANES * BEATS;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [LANES-1:0] in_data;
    logic             in_last;
    logic             tb_poison;
    logic             cw_poison;
    logic             cw_valid;
    logic             cw_ready;
    logic [CW_W-1:0]  codeword;
    logic             frame_err;

    rs_burst_deserializer #(.LANES(LANES), .BEATS(BEATS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
`ifdef RS_DESER_POISON_EN
        .in_poison (tb_poison),
        .cw_poison (cw_poison),
`endif
        .cw_valid  (cw_valid),
        .cw_ready  (cw_ready),
        .codeword  (codeword),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Model: pending codewords (output first, then assembly), beats of the open burst.
    logic [CW_W-1:0]  mq[$];
    logic             mpq[$];
    logic [LANES-1:0] beats[$];
    logic             pacc;
    logic             fe_exp;
    logic [CW_W-1:0]  got[$];
    bit               rand_rdy;
    int               n_vec = 0;
    int               n_err = 0;

    task automatic chk(input string nm, input logic [CW_W-1:0] act, input logic [CW_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete(); mpq.delete(); beats.delete();
        pacc = 1'b0; fe_exp = 1'b0;
    endtask

    task automatic step(output bit acc);
        bit a, d;
        logic [CW_W-1:0] c;
        if (rand_rdy) cw_ready = ($urandom_range(1) == 1);
        @(posedge clk);
        a = in_valid && (mq.size() < 2);
        d = (mq.size() > 0) && cw_ready;
        fe_exp = 1'b0;
        if (cw_valid && cw_ready) got.push_back(codeword);
        if (d) begin
            void'(mq.pop_front());
            void'(mpq.pop_front());
        end
        if (a) begin
            if (in_last != (beats.size() == BEATS - 1)) begin
                beats.delete(); pacc = 1'b0; fe_exp = 1'b1;
            end else begin
                beats.push_back(in_data);
                pacc = pacc | tb_poison;
                if (in_last) begin
                    c = '0;
                    for (int b = 0; b < BEATS; b++)
                        for (int i = 0; i < LANES; i++)
                            c[BEATS*i + b] = beats[b][i];
                    mq.push_back(c);
                    mpq.push_back(pacc);
                    beats.delete(); pacc = 1'b0;
                end
            end
        end
        acc = a;
        @(negedge clk);
        chk("in_ready", CW_W'(in_ready), CW_W'(mq.size() < 2));
        chk("cw_valid", CW_W'(cw_valid), CW_W'(mq.size() > 0));
        chk("frame_err", CW_W'(frame_err), CW_W'(fe_exp));
        if (mq.size() > 0) begin
            chk("codeword", codeword, mq[0]);
`ifdef RS_DESER_POISON_EN
            chk("cw_poison", CW_W'(cw_poison), CW_W'(mpq[0]));
`endif
        end
    endtask

    // bad_at: beat whose in_last is inverted (burst ends there); nbeats limits beats sent.
    task automatic send(input logic [CW_W-1:0] cw, input int bad_at, input int nbeats,
                        input bit gaps, input logic [BEATS-1:0] pois, input int release_after);
        bit a;
        int tries;
        for (int b = 0; b < nbeats; b++) begin
            for (int i = 0; i < LANES; i++) in_data[i] = cw[BEATS*i + b];
            in_last = (b == BEATS - 1);
            if (b == bad_at) in_last = !in_last;
            tb_poison = pois[b];
            in_valid  = 1'b1;
            tries = 0; a = 1'b0;
            while (!a && tries < 200) begin
                if (tries == release_after) cw_ready = 1'b1;
                step(a);
                tries++;
            end
            in_valid = 1'b0; in_last = 1'b0; tb_poison = 1'b0;
            if (!a) begin
                n_vec++; n_err++;
                $display("FAIL beat_timeout: beat %0d not accepted, required acceptance", b);
                return;
            end
            if (b == bad_at) return;
            if (gaps && $urandom_range(3) == 0) step(a);
        end
    endtask

    task automatic drain_all();
        bit a;
        int n = 0;
        cw_ready = 1'b1;
        while (mq.size() > 0 && n < 50) begin step(a); n++; end
        chk("drain_empty", CW_W'(mq.size()), '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        model_clear();
        chk("rst_cw_valid", CW_W'(cw_valid), '0);
        chk("rst_codeword", codeword, '0);
        chk("rst_frame_err", CW_W'(frame_err), '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", CW_W'(in_ready), CW_W'(1));
    endtask

    initial begin
        logic [CW_W-1:0] ca, cb, cc;
        bit a;
        int bad;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; tb_poison = 1'b0;
        cw_ready = 1'b1; rand_rdy = 1'b0;
        model_clear();
        @(negedge clk);
        do_reset();

        // Lane 37 on beats 0,2,3,5,7 -> symbol 37 = 8'hAD.
        ca = '0;
        ca[303:296] = 8'hAD;
        send(ca, -1, BEATS, 1'b0, '0, -1);
        chk("t1_latency_valid", CW_W'(cw_valid), CW_W'(1));
        chk("t1_codeword_lit", codeword, CW_W'(8'hAD) << 296);
        step(a);
        chk("t1_valid_drop", CW_W'(cw_valid), '0);

        // Symbol i carries value i.
        for (int i = 0; i < LANES; i++) cb[BEATS*i +: BEATS] = 8'(i);
        send(cb, -1, BEATS, 1'b0, '0, -1);
        for (int i = 0; i < LANES; i++)
            chk("t2_symbol", CW_W'(codeword[BEATS*i +: BEATS]), CW_W'(i));
        drain_all();

        // Stall: two codewords buffered, third burst waits.
        for (int k = 0; k < CW_W; k++) begin
            ca[k] = 1'($urandom_range(1)); cb[k] = 1'($urandom_range(1)); cc[k] = 1'($urandom_range(1));
        end
        cw_ready = 1'b0;
        got.delete();
        send(ca, -1, BEATS, 1'b0, '0, -1);
        send(cb, -1, BEATS, 1'b0, '0, -1);
        chk("t3_in_ready_low", CW_W'(in_ready), '0);
        chk("t3_out_is_first", codeword, ca);
        send(cc, -1, BEATS, 1'b0, '0, 4);
        drain_all();
        chk("t3_got_count", CW_W'(got.size()), CW_W'(3));
        if (got.size() == 3) begin
            chk("t3_order0", got[0], ca);
            chk("t3_order1", got[1], cb);
            chk("t3_order2", got[2], cc);
        end

        // Early in_last at beat 3.
        cw_ready = 1'b1;
        send(ca, 3, BEATS, 1'b0, '0, -1);
        chk("t4_frame_err", CW_W'(frame_err), CW_W'(1));
        chk("t4_no_valid", CW_W'(cw_valid), '0);
        step(a);
        chk("t4_frame_err_pulse", CW_W'(frame_err), '0);
        send(cb, -1, BEATS, 1'b0, '0, -1);
        chk("t4_clean_cw", codeword, cb);
        drain_all();

        // Reset with a codeword held and a burst part-way in.
        cw_ready = 1'b0;
        send(cc, -1, BEATS, 1'b0, '0, -1);
        send(ca, -1, 5, 1'b0, '0, -1);
        do_reset();
        cw_ready = 1'b1;
        send(cb, -1, BEATS, 1'b0, '0, -1);
        chk("t5_after_reset_cw", codeword, cb);
        drain_all();

`ifdef RS_DESER_POISON_EN
        send(ca, -1, BEATS, 1'b0, 8'b0100_0000, -1);
        chk("t6_poison_set", CW_W'(cw_poison), CW_W'(1));
        send(cb, -1, BEATS, 1'b0, '0, -1);
        chk("t6_poison_clear", CW_W'(cw_poison), '0);
        drain_all();
`endif

        // Random traffic with random consumer stalls and occasional framing faults.
        rand_rdy = 1'b1;
        for (int n = 0; n < 60; n++) begin
            for (int k = 0; k < CW_W; k++) ca[k] = 1'($urandom_range(1));
            bad = ($urandom_range(9) == 0) ? int'($urandom_range(BEATS - 1)) : -1;
            send(ca, bad, BEATS, 1'b1, 8'($urandom_range(255)), -1);
        end
        rand_rdy = 1'b0;
        drain_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
